// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream round-robin arbiter.
package axis_pkg;

    // Arbiter FSM states: IDLE arbitrates every cycle, LOCKED holds the grant for a packet.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Width of a port index for n ports (never narrower than one bit).
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : axis_pkg

// File: rtl/axis_rr_select.sv
// Combinational round-robin selector: first requesting port at or after ptr, wrapping.
// Rotates the request vector so ptr lands on bit 0, priority-encodes the lowest set bit,
// then adds ptr back to turn the offset into an absolute port index.
module axis_rr_select
    import axis_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    localparam int ID_WIDTH  = id_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [ID_WIDTH-1:0]  ptr,
    output logic [ID_WIDTH-1:0]  grant,
    output logic                 any_req
);

    localparam logic [ID_WIDTH:0] NUM_PORTS_W = (ID_WIDTH + 1)'(NUM_PORTS);

    logic [2*NUM_PORTS-1:0] doubled;
    logic [NUM_PORTS-1:0]   rotated;
    logic [ID_WIDTH-1:0]    offset;
    logic [ID_WIDTH:0]      sum;

    // Rotate, priority-encode the lowest requester, and map back to an absolute index.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        offset  = '0;
        doubled = {req, req} >> ptr;
        rotated = doubled[NUM_PORTS-1:0];
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = ID_WIDTH'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= NUM_PORTS_W) begin
            grant = ID_WIDTH'(sum - NUM_PORTS_W);
        end else begin
            grant = ID_WIDTH'(sum);
        end
        any_req = |req;
    end

endmodule : axis_rr_select

// File: rtl/axis_rr_arbiter.sv
// N:1 AXI-Stream round-robin arbiter with a registered output stage.
// Optional packet locking is enabled by defining AXIS_ARB_PKT_LOCK_EN; without it the
// arbiter re-arbitrates on every beat and the LOCKED state is never entered.
module axis_rr_arbiter
    import axis_pkg::*;
#(
    parameter  int NUM_PORTS  = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int ID_WIDTH   = id_width(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    output logic                            m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tlast,
    output logic [ID_WIDTH-1:0]             m_axis_tid,
    input  logic                            m_axis_tready
);

    arb_state_t            state, state_next;
    logic [ID_WIDTH-1:0]   ptr, ptr_next;
    logic [ID_WIDTH-1:0]   lock_idx, lock_next;
    logic [ID_WIDTH-1:0]   rr_grant;
    logic [ID_WIDTH-1:0]   grant;
    logic                  any_req;
    logic                  slot_free;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_last;

    // Next port after p, wrapping from NUM_PORTS-1 back to 0.
    function automatic logic [ID_WIDTH-1:0] next_port(input logic [ID_WIDTH-1:0] p);
        return (p == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : p + ID_WIDTH'(1);
    endfunction

    axis_rr_select #(
        .NUM_PORTS (NUM_PORTS)
    ) u_select (
        .req     (s_axis_tvalid),
        .ptr     (ptr),
        .grant   (rr_grant),
        .any_req (any_req)
    );

    // Grant source, upstream ready and the selected beat.
    always_comb begin
        s_axis_tready = '0;
        slot_free     = ~m_axis_tvalid | m_axis_tready;
        grant         = (state == LOCKED) ? lock_idx : rr_grant;
        if (!reset && slot_free && (state == LOCKED || any_req)) begin
            s_axis_tready[grant] = 1'b1;
        end
        accept   = |(s_axis_tvalid & s_axis_tready);
        sel_data = s_axis_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        sel_last = s_axis_tlast[grant];
    end

    // Next-state logic: advance ptr after a finished packet (or every beat without locking).
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        lock_next  = lock_idx;
        if (accept) begin
            case (state)
                IDLE: begin
`ifdef AXIS_ARB_PKT_LOCK_EN
                    if (sel_last) begin
                        ptr_next = next_port(grant);
                    end else begin
                        state_next = LOCKED;
                        lock_next  = grant;
                    end
`else
                    ptr_next = next_port(grant);
`endif
                end
                LOCKED: begin
                    if (sel_last) begin
                        state_next = IDLE;
                        ptr_next   = next_port(lock_idx);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State, round-robin pointer and lock index registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            lock_idx <= '0;
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            lock_idx <= lock_next;
        end
    end

    // Output register: loads on accept, drops valid when the slot empties with nothing new.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tid    <= '0;
        end else if (slot_free) begin
            m_axis_tvalid <= accept;
            if (accept) begin
                m_axis_tdata <= sel_data;
                m_axis_tlast <= sel_last;
                m_axis_tid   <= grant;
            end
        end
    end

endmodule : axis_rr_arbiter

// File: tb/tb_axis_rr_arbiter.sv
// Directed self-checking bench for axis_rr_arbiter (NUM_PORTS=4, DATA_WIDTH=32).
// The packet-lock scenario expects locked ordering when AXIS_ARB_PKT_LOCK_EN is defined.
module tb_axis_rr_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   s_valid;
    logic [127:0] s_data;
    logic [3:0]   s_last;
    logic [3:0]   s_ready;
    logic         m_tvalid;
    logic [31:0]  m_tdata;
    logic         m_tlast;
    logic [1:0]   m_tid;
    logic         m_tready;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] mon_q[$];

    always #5 clk = ~clk;

    axis_rr_arbiter #(
        .NUM_PORTS  (4),
        .DATA_WIDTH (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tvalid (s_valid),
        .s_axis_tdata  (s_data),
        .s_axis_tlast  (s_last),
        .s_axis_tready (s_ready),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tdata  (m_tdata),
        .m_axis_tlast  (m_tlast),
        .m_axis_tid    (m_tid),
        .m_axis_tready (m_tready)
    );

    // Record every downstream handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset && m_tvalid && m_tready) mon_q.push_back(m_tdata);
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s_valid = '0;
        s_data  = '0;
        s_last  = '0;
    endtask

    task automatic set_port(input int p, input logic v, input logic [31:0] d, input logic l);
        s_valid[p]         = v;
        s_data[p*32 +: 32] = d;
        s_last[p]          = l;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        m_tready = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        m_tready = 1'b1;
        clear_inputs();
        s_valid = 4'hF;
        s_last  = 4'hF;
        step();
        n_tests++;
        if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
        n_tests++;
        if (m_tdata !== 32'h0 || m_tlast !== 1'b0 || m_tid !== 2'd0) begin
            n_fail++; $display("FAIL reset_outputs: got data=%h last=%b tid=%0d want 0/0/0", m_tdata, m_tlast, m_tid);
        end
        n_tests++;
        if (s_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_tready: got %b want 0000", s_ready); end
        reset = 1'b0;
        clear_inputs();
        step();
    endtask

    task automatic test_single_port();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            set_port(2, 1'b1, 32'h10 + 32'(k), 1'b1);
            #1;
            n_tests++;
            if (s_ready !== 4'b0100) begin n_fail++; $display("FAIL single_tready[%0d]: got %b want 0100", k, s_ready); end
            step();
            n_tests++;
            if (m_tvalid !== 1'b1 || m_tdata !== 32'h10 + 32'(k) || m_tid !== 2'd2 || m_tlast !== 1'b1) begin
                n_fail++;
                $display("FAIL single_out[%0d]: got v=%b d=%h id=%0d l=%b want 1/%h/2/1",
                         k, m_tvalid, m_tdata, m_tid, m_tlast, 32'h10 + 32'(k));
            end
        end
        clear_inputs();
        step();
        n_tests++;
        if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got tvalid=%b want 0", m_tvalid); end
    endtask

    task automatic test_round_robin();
        int cnt[4] = '{0, 0, 0, 0};
        int exp;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            for (int p = 0; p < 4; p++) set_port(p, 1'b1, 32'(p * 256 + cnt[p]), 1'b1);
            exp = i % 4;
            #1;
            n_tests++;
            if (s_ready !== 4'(1 << exp)) begin n_fail++; $display("FAIL rr_tready[%0d]: got %b want %b", i, s_ready, 4'(1 << exp)); end
            step();
            n_tests++;
            if (m_tvalid !== 1'b1 || m_tid !== 2'(exp) || m_tdata !== 32'(exp * 256 + cnt[exp])) begin
                n_fail++;
                $display("FAIL rr_out[%0d]: got v=%b id=%0d d=%h want 1/%0d/%h",
                         i, m_tvalid, m_tid, m_tdata, exp, 32'(exp * 256 + cnt[exp]));
            end
            cnt[exp]++;
        end
        clear_inputs();
        step();
    endtask

    task automatic test_pkt_lock();
`ifdef AXIS_ARB_PKT_LOCK_EN
        int exp_tab[8] = '{0, 1, 1, 1, 1, 0, 0, 0};
`else
        int exp_tab[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        int n0 = 0;
        int n1 = 0;
        int exp;
        logic [31:0] exp_data;
        logic        exp_last;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_port(0, 1'b1, 32'h50 + 32'(n0), 1'b1);
            set_port(1, (i >= 1) && (n1 < 4), 32'hA0 + 32'(n1), n1 == 3);
            exp = exp_tab[i];
            exp_data = (exp == 0) ? 32'h50 + 32'(n0) : 32'hA0 + 32'(n1);
            exp_last = (exp == 0) ? 1'b1 : (n1 == 3);
            #1;
            n_tests++;
            if (s_ready !== 4'(1 << exp)) begin n_fail++; $display("FAIL lock_tready[%0d]: got %b want %b", i, s_ready, 4'(1 << exp)); end
            step();
            n_tests++;
            if (m_tvalid !== 1'b1 || m_tid !== 2'(exp) || m_tdata !== exp_data || m_tlast !== exp_last) begin
                n_fail++;
                $display("FAIL lock_out[%0d]: got v=%b id=%0d d=%h l=%b want 1/%0d/%h/%b",
                         i, m_tvalid, m_tid, m_tdata, m_tlast, exp, exp_data, exp_last);
            end
            if (exp == 0) n0++; else n1++;
        end
        clear_inputs();
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        mon_q.delete();
        set_port(3, 1'b1, 32'h30, 1'b1);
        #1;
        n_tests++;
        if (s_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_first_tready: got %b want 1000", s_ready); end
        step();
        set_port(3, 1'b1, 32'h31, 1'b1);
        m_tready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++;
            if (s_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_tready[%0d]: got %b want 0000", c, s_ready); end
            step();
            n_tests++;
            if (m_tvalid !== 1'b1 || m_tdata !== 32'h30 || m_tid !== 2'd3) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v=%b d=%h id=%0d want 1/00000030/3", c, m_tvalid, m_tdata, m_tid);
            end
        end
        m_tready = 1'b1;
        #1;
        n_tests++;
        if (s_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_release_tready: got %b want 1000", s_ready); end
        step();
        n_tests++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'h31) begin
            n_fail++; $display("FAIL bp_next: got v=%b d=%h want 1/00000031", m_tvalid, m_tdata);
        end
        clear_inputs();
        step();
        n_tests++;
        if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got tvalid=%b want 0", m_tvalid); end
        @(negedge clk);
        #1;
        n_tests++;
        if (mon_q.size() != 2) begin
            n_fail++; $display("FAIL bp_count: got %0d beats want 2", mon_q.size());
        end else if (mon_q[0] !== 32'h30 || mon_q[1] !== 32'h31) begin
            n_fail++; $display("FAIL bp_order: got %h,%h want 00000030,00000031", mon_q[0], mon_q[1]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        set_port(2, 1'b1, 32'h20, 1'b1);
        step();
        clear_inputs();
        set_port(0, 1'b1, 32'hC0, 1'b1);
        set_port(3, 1'b1, 32'hC3, 1'b1);
        #1;
        n_tests++;
        if (s_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_first_tready: got %b want 1000", s_ready); end
        step();
        n_tests++;
        if (m_tid !== 2'd3 || m_tdata !== 32'hC3) begin n_fail++; $display("FAIL wrap_first: got id=%0d d=%h want 3/000000c3", m_tid, m_tdata); end
        set_port(3, 1'b0, 32'h0, 1'b0);
        #1;
        n_tests++;
        if (s_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_second_tready: got %b want 0001", s_ready); end
        step();
        n_tests++;
        if (m_tid !== 2'd0 || m_tdata !== 32'hC0) begin n_fail++; $display("FAIL wrap_second: got id=%0d d=%h want 0/000000c0", m_tid, m_tdata); end
        clear_inputs();
        step();
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        set_port(1, 1'b1, 32'hB0, 1'b0);
        step();
        m_tready = 1'b0;
        set_port(0, 1'b1, 32'hD0, 1'b1);
        set_port(1, 1'b1, 32'hB1, 1'b0);
        set_port(3, 1'b1, 32'hD3, 1'b1);
        step();
        n_tests++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'hB0) begin n_fail++; $display("FAIL mid_held: got v=%b d=%h want 1/000000b0", m_tvalid, m_tdata); end
        reset = 1'b1;
        #1;
        n_tests++;
        if (s_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_tready: got %b want 0000", s_ready); end
        step();
        reset = 1'b0;
        n_tests++;
        if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_tvalid: got %b want 0", m_tvalid); end
        m_tready = 1'b1;
        #1;
        n_tests++;
        if (s_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_grant_tready: got %b want 0001", s_ready); end
        step();
        n_tests++;
        if (m_tvalid !== 1'b1 || m_tid !== 2'd0 || m_tdata !== 32'hD0) begin
            n_fail++; $display("FAIL mid_grant: got v=%b id=%0d d=%h want 1/0/000000d0", m_tvalid, m_tid, m_tdata);
        end
        clear_inputs();
        step();
    endtask

    initial begin
        reset    = 1'b1;
        m_tready = 1'b1;
        clear_inputs();
        test_reset();
        test_single_port();
        test_round_robin();
        test_pkt_lock();
        test_backpressure();
        test_wrap();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_axis_rr_arbiter
